// File: rtl/isa_io_cycle_controller.sv
// ISA I/O cycle sequencer for the sm2201 board address window.
// Drives the 82x6 transceiver and the CAMAC request handshake.
module isa_io_cycle_controller #(
  parameter logic [9:0] BASE_ADDR       = 10'h300,
  parameter int         ADDR_BITS       = 4,
  parameter int         SETUP_CYCLES    = 1,
  parameter int         MAX_WAIT        = 15,
  parameter int         RECOVERY_CYCLES = 2
) (
  input  logic                 isa_clk,
  input  logic                 isa_reset,
  input  logic [9:0]           isa_addr,
  input  logic                 isa_aen,
  input  logic                 isa_ior,
  input  logic                 isa_iow,
  output logic                 isa_iochrdy,
  output logic                 buf_cs_n,
  output logic                 buf_dce,
  output logic                 camac_req,
  output logic                 camac_wr,
  output logic [ADDR_BITS-1:0] camac_sub,
  input  logic                 camac_ack,
  output logic                 busy,
  output logic                 timeout,
  output logic                 abort_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_READY,
    S_RECOVER
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);
  localparam logic [7:0] REC_LAST   = 8'(RECOVERY_CYCLES - 1);

  state_t state;
  state_t state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;

  logic ior_m;
  logic ior_s;
  logic iow_m;
  logic iow_s;

  logic armed;
  logic armed_nx;

  logic hit;
  logic one_low;
  logic both_low;
  logic both_high;
  logic act_high;

  logic                 cs_n_nx;
  logic                 dce_nx;
  logic                 rdy_nx;
  logic                 req_nx;
  logic                 wr_nx;
  logic [ADDR_BITS-1:0] sub_nx;
  logic                 to_nx;
  logic                 ab_nx;

  assign hit = !isa_aen &&
    (isa_addr[9:ADDR_BITS] == BASE_ADDR[9:ADDR_BITS]);

  assign one_low   = ior_s ^ iow_s;
  assign both_low  = !ior_s && !iow_s;
  assign both_high = ior_s && iow_s;

  // strobe that qualifies the cycle in flight
  assign act_high = camac_wr ? iow_s : ior_s;

  // two-stage synchronisers for the asynchronous strobes
  always_ff @(posedge isa_clk) begin
    if (isa_reset) begin
      ior_m <= 1'b1;
      ior_s <= 1'b1;
      iow_m <= 1'b1;
      iow_s <= 1'b1;
    end else begin
      ior_m <= isa_ior;
      ior_s <= ior_m;
      iow_m <= isa_iow;
      iow_s <= iow_m;
    end
  end

  // next state and next registered outputs
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    armed_nx = armed;
    cs_n_nx  = buf_cs_n;
    dce_nx   = buf_dce;
    rdy_nx   = isa_iochrdy;
    req_nx   = camac_req;
    wr_nx    = camac_wr;
    sub_nx   = camac_sub;
    to_nx    = 1'b0;
    ab_nx    = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (!armed) begin
          if (both_high) armed_nx = 1'b1;
        end else if (hit && both_low) begin
          ab_nx    = 1'b1;
          armed_nx = 1'b0;
        end else if (hit && one_low) begin
          state_nx = S_SETUP;
          cnt_nx   = 8'd0;
          cs_n_nx  = 1'b0;
          dce_nx   = iow_s;
          rdy_nx   = 1'b0;
          wr_nx    = !iow_s;
          sub_nx   = isa_addr[ADDR_BITS-1:0];
        end
      end

      S_SETUP: begin
        if (act_high) begin
          state_nx = S_RECOVER;
          cnt_nx   = 8'd0;
          cs_n_nx  = 1'b1;
          rdy_nx   = 1'b1;
          ab_nx    = 1'b1;
        end else if (cnt == SETUP_LAST) begin
          state_nx = S_WAIT;
          cnt_nx   = 8'd0;
          req_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end

      S_WAIT: begin
        if (camac_ack) begin
          state_nx = S_READY;
          cnt_nx   = 8'd0;
          req_nx   = 1'b0;
          rdy_nx   = 1'b1;
        end else if (act_high) begin
          state_nx = S_RECOVER;
          cnt_nx   = 8'd0;
          cs_n_nx  = 1'b1;
          req_nx   = 1'b0;
          rdy_nx   = 1'b1;
          ab_nx    = 1'b1;
        end else if (cnt == WAIT_LAST) begin
          state_nx = S_READY;
          cnt_nx   = 8'd0;
          req_nx   = 1'b0;
          rdy_nx   = 1'b1;
          to_nx    = 1'b1;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end

      S_READY: begin
        if (act_high) begin
          state_nx = S_RECOVER;
          cnt_nx   = 8'd0;
          cs_n_nx  = 1'b1;
        end
      end

      S_RECOVER: begin
        if (cnt == REC_LAST) begin
          state_nx = S_IDLE;
          cnt_nx   = 8'd0;
          dce_nx   = 1'b0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end

      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // state, counter and output registers
  always_ff @(posedge isa_clk) begin
    if (isa_reset) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      armed       <= 1'b1;
      buf_cs_n    <= 1'b1;
      buf_dce     <= 1'b0;
      isa_iochrdy <= 1'b1;
      camac_req   <= 1'b0;
      camac_wr    <= 1'b0;
      camac_sub   <= '0;
      busy        <= 1'b0;
      timeout     <= 1'b0;
      abort_err   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      armed       <= armed_nx;
      buf_cs_n    <= cs_n_nx;
      buf_dce     <= dce_nx;
      isa_iochrdy <= rdy_nx;
      camac_req   <= req_nx;
      camac_wr    <= wr_nx;
      camac_sub   <= sub_nx;
      busy        <= (state_nx != S_IDLE);
      timeout     <= to_nx;
      abort_err   <= ab_nx;
    end
  end

endmodule

// File: tb/tb_isa_io_cycle_controller.sv
// Bench for isa_io_cycle_controller: directed cases plus
// randomized cycles against a phase-level reference model.
module tb_isa_io_cycle_controller;

  localparam int BASE  = 'h300;
  localparam int AB    = 4;
  localparam int SETUP = 1;
  localparam int MAXW  = 15;
  localparam int RECOV = 2;

  logic          isa_clk = 1'b0;
  logic          isa_reset = 1'b1;
  logic [9:0]    isa_addr = '0;
  logic          isa_aen = 1'b0;
  logic          isa_ior = 1'b1;
  logic          isa_iow = 1'b1;
  logic          isa_iochrdy;
  logic          buf_cs_n;
  logic          buf_dce;
  logic          camac_req;
  logic          camac_wr;
  logic [AB-1:0] camac_sub;
  logic          camac_ack = 1'b0;
  logic          busy;
  logic          timeout;
  logic          abort_err;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  isa_io_cycle_controller #(
    .BASE_ADDR(10'h300),
    .ADDR_BITS(AB),
    .SETUP_CYCLES(SETUP),
    .MAX_WAIT(MAXW),
    .RECOVERY_CYCLES(RECOV)
  ) dut (
    .isa_clk(isa_clk),
    .isa_reset(isa_reset),
    .isa_addr(isa_addr),
    .isa_aen(isa_aen),
    .isa_ior(isa_ior),
    .isa_iow(isa_iow),
    .isa_iochrdy(isa_iochrdy),
    .buf_cs_n(buf_cs_n),
    .buf_dce(buf_dce),
    .camac_req(camac_req),
    .camac_wr(camac_wr),
    .camac_sub(camac_sub),
    .camac_ack(camac_ack),
    .busy(busy),
    .timeout(timeout),
    .abort_err(abort_err)
  );

  always #5 isa_clk = ~isa_clk;

  task automatic chk(input string nm,
                     input logic [9:0] act,
                     input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // --- reference model: phases with elapsed-cycle timers ---
  typedef enum int {P_IDLE, P_SETUP, P_WAIT, P_READY, P_REC} ph_e;

  ph_e      ph = P_IDLE;
  int       t = 0;
  bit       m_wr = 0;
  int       m_sub = 0;
  bit       m_armed = 1;
  bit       m_to = 0;
  bit       m_ab = 0;
  bit       r1 = 1, r2 = 1, w1 = 1, w2 = 1;

  always @(posedge isa_clk) begin
    bit sr, sw, ah, hit;
    sr  = r2;
    sw  = w2;
    ah  = m_wr ? sw : sr;
    hit = !isa_aen && ((int'(isa_addr) >> AB) == (BASE >> AB));
    m_to = 0;
    m_ab = 0;
    if (isa_reset) begin
      ph = P_IDLE; t = 0; m_wr = 0; m_sub = 0; m_armed = 1;
      r1 = 1; r2 = 1; w1 = 1; w2 = 1;
    end else begin
      t++;
      case (ph)
        P_IDLE:
          if (!m_armed) begin
            if (sr && sw) m_armed = 1;
          end else if (hit && !sr && !sw) begin
            m_ab = 1; m_armed = 0;
          end else if (hit && (sr != sw)) begin
            ph = P_SETUP; t = 0; m_wr = !sw;
            m_sub = int'(isa_addr) % (1 << AB);
          end
        P_SETUP:
          if (ah) begin
            m_ab = 1; ph = P_REC; t = 0;
          end else if (t == SETUP) begin
            ph = P_WAIT; t = 0;
          end
        P_WAIT:
          if (camac_ack) begin
            ph = P_READY; t = 0;
          end else if (ah) begin
            m_ab = 1; ph = P_REC; t = 0;
          end else if (t == MAXW) begin
            m_to = 1; ph = P_READY; t = 0;
          end
        P_READY:
          if (ah) begin
            ph = P_REC; t = 0;
          end
        P_REC:
          if (t == RECOV) begin
            ph = P_IDLE; t = 0;
          end
        default: ph = P_IDLE;
      endcase
      r2 = r1; r1 = isa_ior;
      w2 = w1; w1 = isa_iow;
    end
  end

  // every-cycle comparison against the model
  always @(negedge isa_clk) begin
    bit sel, drv;
    if (chk_en) begin
      sel = (ph == P_SETUP) || (ph == P_WAIT) || (ph == P_READY);
      drv = sel || (ph == P_REC);
      chk("cs_n", 10'(buf_cs_n), 10'(!sel));
      chk("dce", 10'(buf_dce), 10'(drv && !m_wr));
      chk("iochrdy", 10'(isa_iochrdy),
          10'(!(ph == P_SETUP || ph == P_WAIT)));
      chk("req", 10'(camac_req), 10'(ph == P_WAIT));
      chk("wr", 10'(camac_wr), 10'(m_wr));
      chk("sub", 10'(camac_sub), 10'(m_sub));
      chk("busy", 10'(busy), 10'(ph != P_IDLE));
      chk("timeout", 10'(timeout), 10'(m_to));
      chk("abort", 10'(abort_err), 10'(m_ab));
    end
  end

  // --- directed helpers ---
  task automatic tick(input int n);
    repeat (n) @(negedge isa_clk);
  endtask

  // {cs_n, dce, iochrdy, req, busy}
  task automatic want(input string nm, input logic [4:0] w);
    chk(nm, {5'b0, buf_cs_n, buf_dce, isa_iochrdy, camac_req, busy},
        {5'b0, w});
  endtask

  initial begin
    tick(3);
    chk_en = 1'b1;
    want("rst_out", 5'b10100);
    chk("rst_sub", 10'(camac_sub), 10'd0);
    chk("rst_flags", 10'({timeout, abort_err, camac_wr}), 10'd0);
    isa_reset = 1'b0;
    tick(2);

    // T3: out of window, then DMA cycle
    isa_addr = 10'h310; isa_ior = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1); want("t3_miss", 5'b10100);
    end
    isa_ior = 1'b1; tick(2);
    isa_aen = 1'b1; isa_addr = 10'h305; isa_ior = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(1); want("t3_aen", 5'b10100);
      chk("t3_sub", 10'(camac_sub), 10'd0);
    end
    isa_ior = 1'b1; tick(2); isa_aen = 1'b0;

    // T1: read 0x305, ack on third WAIT edge
    isa_addr = 10'h305; isa_ior = 1'b0;
    tick(1); want("t1_e0", 5'b10100);
    tick(1); want("t1_e1", 5'b10100);
    tick(1); want("t1_cs", 5'b01001);
    chk("t1_sub", 10'(camac_sub), 10'h5);
    chk("t1_wr", 10'(camac_wr), 10'd0);
    tick(1); want("t1_wait", 5'b01011);
    tick(2); want("t1_wait3", 5'b01011);
    camac_ack = 1'b1;
    tick(1); want("t1_ready", 5'b01101);
    camac_ack = 1'b0;
    tick(2); want("t1_hold", 5'b01101);
    isa_ior = 1'b1;
    tick(2); want("t1_sync", 5'b01101);
    tick(1); want("t1_rec", 5'b11101);
    tick(1); want("t1_rec2", 5'b11101);
    tick(1); want("t1_idle", 5'b10100);
    tick(2);

    // T2: write 0x30F, ack on first WAIT edge
    isa_addr = 10'h30f; isa_iow = 1'b0;
    tick(3); want("t2_cs", 5'b00001);
    chk("t2_sub", 10'(camac_sub), 10'hf);
    chk("t2_wr", 10'(camac_wr), 10'd1);
    tick(1); want("t2_req", 5'b00011);
    camac_ack = 1'b1;
    tick(1); want("t2_ready", 5'b00101);
    camac_ack = 1'b0;
    isa_iow = 1'b1;
    tick(3); want("t2_rec", 5'b10101);
    tick(2); want("t2_idle", 5'b10100);
    tick(2);

    // T4: read 0x300, no ack
    isa_addr = 10'h300; isa_ior = 1'b0;
    tick(3); want("t4_cs", 5'b01001);
    for (int i = 0; i < MAXW; i++) begin
      tick(1); want("t4_req", 5'b01011);
    end
    tick(1); want("t4_to", 5'b01101);
    chk("t4_pulse", 10'(timeout), 10'd1);
    tick(1); chk("t4_pulse_end", 10'(timeout), 10'd0);
    isa_ior = 1'b1;
    tick(3); want("t4_rec", 5'b11101);
    tick(2); want("t4_idle", 5'b10100);
    tick(2);

    // T5: write 0x302, early release in WAIT
    isa_addr = 10'h302; isa_iow = 1'b0;
    tick(4); want("t5_wait", 5'b00011);
    isa_iow = 1'b1;
    tick(2); want("t5_sync", 5'b00011);
    tick(1); want("t5_abort", 5'b10101);
    chk("t5_ab", 10'(abort_err), 10'd1);
    camac_ack = 1'b1;
    tick(1); want("t5_late_ack", 5'b10101);
    chk("t5_ab_end", 10'(abort_err), 10'd0);
    camac_ack = 1'b0;
    tick(1); want("t5_idle", 5'b10100);
    tick(2);

    // T6: reset in WAIT, then both strobes low
    isa_addr = 10'h301; isa_ior = 1'b0;
    tick(4); want("t6_wait", 5'b01011);
    isa_reset = 1'b1; isa_ior = 1'b1;
    tick(1); want("t6_rst", 5'b10100);
    chk("t6_sub", 10'(camac_sub), 10'd0);
    isa_reset = 1'b0;
    tick(2);
    isa_ior = 1'b0; isa_iow = 1'b0;
    tick(2); chk("t6_ab_pre", 10'(abort_err), 10'd0);
    tick(1); chk("t6_ab", 10'(abort_err), 10'd1);
    want("t6_idle", 5'b10100);
    tick(1); chk("t6_ab_end", 10'(abort_err), 10'd0);
    tick(3); want("t6_noarm", 5'b10100);
    isa_ior = 1'b1; isa_iow = 1'b1;
    tick(4);

    // randomized cycles
    for (int n = 0; n < 300; n++) begin
      int kind, hold, ackt, gap, rstt, dur;
      kind = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 25));
      ackt = ($urandom_range(0, 4) == 0) ? -1
             : int'($urandom_range(0, 22));
      gap  = int'($urandom_range(0, 6));
      rstt = -1;
      dur  = ((hold > ackt) ? hold : ackt) + gap;
      if ($urandom_range(0, 29) == 0)
        rstt = int'($urandom_range(0, dur));
      isa_aen = (kind == 1);
      if (kind == 0)
        isa_addr = 10'($urandom_range(0, 1023));
      else
        isa_addr = 10'(BASE + int'($urandom_range(0, 15)));
      for (int c = 0; c <= dur; c++) begin
        bit low, rd;
        low = (c < hold);
        rd  = (kind >= 6);
        isa_ior = !(low && (rd || kind == 2 || kind == 0 || kind == 1));
        isa_iow = !(low && (!rd || kind == 2));
        camac_ack = (c == ackt);
        isa_reset = (c == rstt);
        tick(1);
      end
      isa_ior = 1'b1; isa_iow = 1'b1;
      camac_ack = 1'b0; isa_reset = 1'b0;
    end
    tick(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
